data_mem_initiator: RTL and testbench

- Load/store/stack access controller for the processor's memory stage.
- Drives the 16-bit single-port-style data memory on its requester side: read_enable/read_addr, write_enable/write_addr/write_data, read_data.
- Accepts one request at a time from the pipeline over a valid/ready handshake, and sequences one or two 16-bit memory accesses per request.
- Owns the stack pointer (SP); returns a one-cycle response.

---
 rtl/data_mem_initiator_if.sv | 31 +++
 rtl/data_mem_initiator.sv | 179 +++++++++++++++++
 tb/tb_data_mem_initiator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_initiator_if.sv
// Pipeline request/response channel, stack pointer view and data-memory requester port.
// The master modport is the initiator's view; the slave modport is the pipeline-plus-memory side.
interface data_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] sp_out;
    logic        mem_read_enable;
    logic [15:0] mem_read_addr;
    logic [15:0] mem_read_data;
    logic        mem_write_enable;
    logic [15:0] mem_write_addr;
    logic [15:0] mem_write_data;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_err, resp_rdata, sp_out,
               mem_read_enable, mem_read_addr, mem_write_enable, mem_write_addr, mem_write_data
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_err, resp_rdata, sp_out,
               mem_read_enable, mem_read_addr, mem_write_enable, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/data_mem_initiator.sv
// Load/store/stack controller: one request at a time, one or two 16-bit memory accesses, owns SP.
// Latency: error 1 cycle, single-word 2 cycles, double-word 3 cycles; req_ready only in IDLE.
module data_mem_initiator #(
    parameter int unsigned MEM_DEPTH = 2045,
    parameter logic [15:0] SP_INIT   = 16'h07FC
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_PUSH2 = 3'd4;
    localparam logic [2:0] OP_POP2  = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a0_q, a0_d, a1_q, a1_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_ready;
    logic        re, we;
    logic [15:0] raddr, waddr, wdat;
    logic [15:0] na0, na1;
    logic        two, illegal, is_write;

    function automatic logic in_range(input logic [15:0] a);
        return 32'(a) < MEM_DEPTH;
    endfunction

    function automatic logic [15:0] sp_next(input logic [2:0] op, input logic [15:0] sp);
        case (op)
            OP_PUSH:  return sp - 16'd1;
            OP_POP:   return sp + 16'd1;
            OP_PUSH2: return sp - 16'd2;
            OP_POP2:  return sp + 16'd2;
            default:  return sp;
        endcase
    endfunction

    assign is_write = (op_q == OP_STORE) || (op_q == OP_PUSH) || (op_q == OP_PUSH2);

    // Access addresses for the request currently on the bus, computed from the live SP.
    always_comb begin
        na0     = 16'h0;
        na1     = 16'h0;
        two     = 1'b0;
        illegal = 1'b0;
        case (bus.req_op)
            OP_LOAD, OP_STORE: na0 = bus.req_addr;
            OP_PUSH:           na0 = sp_q;
            OP_POP:            na0 = sp_q + 16'd1;
            OP_PUSH2: begin
                na0 = sp_q;
                na1 = sp_q - 16'd1;
                two = 1'b1;
            end
            OP_POP2: begin
                na0 = sp_q + 16'd1;
                na1 = sp_q + 16'd2;
                two = 1'b1;
            end
            default:           illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a0_d      = a0_q;
        a1_d      = a1_q;
        wdata_d   = wdata_q;
        sp_d      = sp_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        re        = 1'b0;
        we        = 1'b0;
        raddr     = 16'h0;
        waddr     = 16'h0;
        wdat      = 16'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    a0_d    = na0;
                    a1_d    = na1;
                    wdata_d = bus.req_wdata;
                    lo_d    = 16'h0;
                    err_d   = illegal || !in_range(na0) || (two && !in_range(na1));
                    if (err_d) begin
                        rdata_d = 32'h0;
                        state_d = DONE;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                if (is_write) begin
                    we    = 1'b1;
                    waddr = a0_q;
                    wdat  = (op_q == OP_PUSH2) ? wdata_q[31:16] : wdata_q[15:0];
                end else begin
                    re    = 1'b1;
                    raddr = a0_q;
                end
                if (op_q == OP_PUSH2 || op_q == OP_POP2) begin
                    lo_d    = bus.mem_read_data;
                    state_d = ACC1;
                end else begin
                    rdata_d = is_write ? 32'h0 : {16'h0, bus.mem_read_data};
                    sp_d    = sp_next(op_q, sp_q);
                    state_d = DONE;
                end
            end
            ACC1: begin
                if (op_q == OP_PUSH2) begin
                    we      = 1'b1;
                    waddr   = a1_q;
                    wdat    = wdata_q[15:0];
                    rdata_d = 32'h0;
                end else begin
                    re      = 1'b1;
                    raddr   = a1_q;
                    rdata_d = {bus.mem_read_data, lo_q};
                end
                sp_d    = sp_next(op_q, sp_q);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            a0_q    <= 16'h0;
            a1_q    <= 16'h0;
            wdata_q <= 32'h0;
            sp_q    <= SP_INIT;
            lo_q    <= 16'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            wdata_q <= wdata_d;
            sp_q    <= sp_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready        = req_ready;
    assign bus.resp_valid       = (state_q == DONE);
    assign bus.resp_err         = err_q;
    assign bus.resp_rdata       = rdata_q;
    assign bus.sp_out           = sp_q;
    assign bus.mem_read_enable  = re;
    assign bus.mem_read_addr    = raddr;
    assign bus.mem_write_enable = we;
    assign bus.mem_write_addr   = waddr;
    assign bus.mem_write_data   = wdat;
endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed vector bench for data_mem_initiator with a negedge-updating behavioural memory.
module tb_data_mem_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_initiator_if bus();
    data_mem_initiator dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] mem [0:2047];
    initial bus.mem_read_data = 16'h0;
    always @(negedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_write_addr[10:0]] <= bus.mem_write_data;
        if (bus.mem_read_enable)  bus.mem_read_data <= mem[bus.mem_read_addr[10:0]];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [15:0] sp;
        int          lat;
        int          wr;
        int          rd;
        logic [15:0] a0;
    } vec_t;

    task automatic run_vec(input vec_t v, input string name);
        int lat = 0;
        int wr = 0;
        int rd = 0;
        int both = 0;
        logic [15:0] first = 16'h0;
        bit seen = 0;
        logic [31:0] rdata_seen = 32'h0;
        @(negedge clk);
        chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.mem_write_enable && bus.mem_read_enable) both++;
            if (bus.mem_write_enable) begin
                wr++;
                if (!seen) first = bus.mem_write_addr;
                seen = 1;
            end else if (bus.mem_read_enable) begin
                rd++;
                if (!seen) first = bus.mem_read_addr;
                seen = 1;
            end
            if (bus.resp_valid) begin
                lat = c;
                chk({name, "_err"}, 32'(bus.resp_err), 32'(v.err));
                chk({name, "_rdata"}, bus.resp_rdata, v.rdata);
                chk({name, "_sp"}, 32'(bus.sp_out), 32'(v.sp));
                rdata_seen = bus.resp_rdata;
            end
        end
        chk({name, "_lat"}, 32'(lat), 32'(v.lat));
        chk({name, "_wr"}, 32'(wr), 32'(v.wr));
        chk({name, "_rd"}, 32'(rd), 32'(v.rd));
        chk({name, "_both"}, 32'(both), 32'd0);
        if (v.wr + v.rd > 0) chk({name, "_a0"}, 32'(first), 32'(v.a0));
        @(negedge clk);
        chk({name, "_hold"}, bus.resp_rdata, rdata_seen);
        chk({name, "_one_pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    vec_t vecs [13];

    initial begin
        int pulses;
        int ens;
        vecs[0]  = '{3'd1, 16'h0010, 32'h0000_1234, 1'b0, 32'h0,         16'h07FC, 2, 1, 0, 16'h0010};
        vecs[1]  = '{3'd0, 16'h0010, 32'h0,         1'b0, 32'h0000_1234, 16'h07FC, 2, 0, 1, 16'h0010};
        vecs[2]  = '{3'd2, 16'h0,    32'h0000_BEEF, 1'b0, 32'h0,         16'h07FB, 2, 1, 0, 16'h07FC};
        vecs[3]  = '{3'd3, 16'h0,    32'h0,         1'b0, 32'h0000_BEEF, 16'h07FC, 2, 0, 1, 16'h07FC};
        vecs[4]  = '{3'd4, 16'h0,    32'hCAFE_F00D, 1'b0, 32'h0,         16'h07FA, 3, 2, 0, 16'h07FC};
        vecs[5]  = '{3'd5, 16'h0,    32'h0,         1'b0, 32'hCAFE_F00D, 16'h07FC, 3, 0, 2, 16'h07FB};
        vecs[6]  = '{3'd3, 16'h0,    32'h0,         1'b1, 32'h0,         16'h07FC, 1, 0, 0, 16'h0};
        vecs[7]  = '{3'd0, 16'h0800, 32'h0,         1'b1, 32'h0,         16'h07FC, 1, 0, 0, 16'h0};
        vecs[8]  = '{3'd0, 16'h07FC, 32'h0,         1'b0, 32'h0000_CAFE, 16'h07FC, 2, 0, 1, 16'h07FC};
        vecs[9]  = '{3'd6, 16'h0,    32'h0,         1'b1, 32'h0,         16'h07FC, 1, 0, 0, 16'h0};
        vecs[10] = '{3'd1, 16'h07FC, 32'hAAAA_5555, 1'b0, 32'h0,         16'h07FC, 2, 1, 0, 16'h07FC};
        vecs[11] = '{3'd0, 16'h07FC, 32'h0,         1'b0, 32'h0000_5555, 16'h07FC, 2, 0, 1, 16'h07FC};
        vecs[12] = '{3'd5, 16'h0,    32'h0,         1'b1, 32'h0,         16'h07FC, 1, 0, 0, 16'h0};

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sp", 32'(bus.sp_out), 32'h07FC);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_outs", {bus.mem_read_enable, bus.mem_write_enable, bus.mem_read_addr,
                             bus.mem_write_addr[13:0]}, 32'h0);
        chk("rst_wdata", 32'(bus.mem_write_data), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 2) chk("push_mem", 32'(mem[11'h7FC]), 32'h0000_BEEF);
            if (i == 4) begin
                chk("push2_mem_hi", 32'(mem[11'h7FC]), 32'h0000_CAFE);
                chk("push2_mem_lo", 32'(mem[11'h7FB]), 32'h0000_F00D);
            end
        end

        // Reset in the middle of a PUSH2 second access
        run_vec('{3'd2, 16'h0, 32'h0000_1111, 1'b0, 32'h0, 16'h07FB, 2, 1, 0, 16'h07FC}, "pre_push");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd4;
        bus.req_wdata = 32'h2222_3333;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("acc1_we", 32'(bus.mem_write_enable), 32'd1);
        chk("acc1_waddr", 32'(bus.mem_write_addr), 32'h07FA);
        chk("acc1_wdata", 32'(bus.mem_write_data), 32'h3333);
        rst = 1'b1;
        #1;
        chk("mid_rst_en", {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h0);
        chk("mid_rst_waddr", 32'(bus.mem_write_addr), 32'h0);
        chk("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_sp", 32'(bus.sp_out), 32'h07FC);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        ens = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
            if (bus.mem_read_enable || bus.mem_write_enable) ens++;
        end
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_pulses", 32'(pulses), 32'd0);
        chk("post_rst_enables", 32'(ens), 32'd0);
        chk("post_rst_sp", 32'(bus.sp_out), 32'h07FC);

        // Illegal op held across DONE: single response, not re-accepted in DONE
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd7;
        @(posedge clk);
        @(negedge clk);
        chk("op7_resp", 32'(bus.resp_valid), 32'd1);
        chk("op7_err", 32'(bus.resp_err), 32'd1);
        chk("op7_ready_done", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("op7_idle_resp", 32'(bus.resp_valid), 32'd0);
        chk("op7_idle_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        chk("op7_no_repeat", 32'(pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
